// File: rtl/error_sampler_pkg.sv
// ============================================================================
// Module      : error_sampler_pkg
// Description : Shared widths, FSM state type and ternary pair selector for
//               the error polynomial sampler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package error_sampler_pkg;

    localparam int ETA        = 21;
    localparam int RND_W      = 64;
    localparam int V_W        = 2;
    localparam int E_W        = 6;
    localparam int TERN_PAIRS = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    typedef struct packed {
        logic           hit;
        logic [V_W-1:0] v;
    } tern_sel_t;

    // Rejection sampler for the ternary coefficient: the lowest pair that is
    // not 2'b11 wins; 2'b10 maps to the sign+magnitude code for -1.
    function automatic tern_sel_t select_ternary(input logic [2*TERN_PAIRS-1:0] pairs);
        tern_sel_t r;
        r.hit = 1'b0;
        r.v   = '0;
        for (int i = TERN_PAIRS - 1; i >= 0; i--) begin
            if (pairs[2*i +: 2] != 2'b11) begin
                r.hit = 1'b1;
                r.v   = (pairs[2*i +: 2] == 2'b10) ? 2'b11 : pairs[2*i +: 2];
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cbd_popcount.sv
// ============================================================================
// Module      : cbd_popcount
// Description : Combinational population count of one ETA-bit CBD half-word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cbd_popcount
    import error_sampler_pkg::*;
(
    input  logic [ETA-1:0] i_bits,
    output logic [4:0]     o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < ETA; i++) begin
            o_count = o_count + 5'(i_bits[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/error_poly_sampler.sv
// ============================================================================
// Module      : error_poly_sampler
// Description : Samples one ternary (v) and one CBD (e1) polynomial pair from
//               a 64-bit random stream and writes them to BRAM in order.
//               Optional macro ERROR_SAMPLER_STATS_EN adds reject_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module error_poly_sampler
    import error_sampler_pkg::*;
#(
    parameter int N    = 8192,
    parameter int LOGN = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic [RND_W-1:0] rnd_data,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    output logic [LOGN-1:0]  error_bram_wr_addr,
    output logic [V_W-1:0]   v_bram_wr_data,
    output logic [E_W-1:0]   e1_bram_wr_data,
    output logic             error_bram_wea
`ifdef ERROR_SAMPLER_STATS_EN
    ,
    output logic [15:0]      reject_count
`endif
);

    localparam logic [LOGN-1:0] c_last = LOGN'(N - 1);

    state_t          r_state;
    state_t          w_state_next;

    logic            w_start_ok;
    logic            w_xfer;
    tern_sel_t       w_tern;
    logic            w_keep;
    logic            w_drop;
    logic            w_last_kept;
    logic            w_last_write;
    logic [4:0]      w_pop_a;
    logic [4:0]      w_pop_b;
    logic [4:0]      w_mag;
    logic [E_W-1:0]  w_e;
    logic            w_unused;

    logic [LOGN-1:0] r_kept_cnt;
    logic [LOGN-1:0] r_addr_cnt;
    logic            r_s1_valid;
    logic [4:0]      r_s1_pop_a;
    logic [4:0]      r_s1_pop_b;
    logic [V_W-1:0]  r_s1_v;
    logic            r_wea;
    logic [LOGN-1:0] r_wr_addr;
    logic [V_W-1:0]  r_v;
    logic [E_W-1:0]  r_e;
    logic            r_done;

    assign w_unused = &{1'b0, rnd_data[43:42]};

    cbd_popcount u_pop_a (
        .i_bits  (rnd_data[ETA-1:0]),
        .o_count (w_pop_a)
    );

    cbd_popcount u_pop_b (
        .i_bits  (rnd_data[2*ETA-1:ETA]),
        .o_count (w_pop_b)
    );

    // A start coinciding with done is dropped: the run has only just ended.
    assign w_start_ok   = start && (r_state == ST_IDLE) && !r_done;
    assign rnd_ready    = (r_state == ST_SAMPLE);
    assign w_xfer       = rnd_valid && rnd_ready;
    assign w_tern       = select_ternary(rnd_data[RND_W-1:RND_W-2*TERN_PAIRS]);
    assign w_keep       = w_xfer && w_tern.hit;
    assign w_drop       = w_xfer && !w_tern.hit;
    assign w_last_kept  = w_keep && (r_kept_cnt == c_last);
    assign w_last_write = r_wea && (r_wr_addr == c_last);

    // Magnitude is formed directly so equal counts can never yield -0.
    assign w_mag = (r_s1_pop_a >= r_s1_pop_b) ? (r_s1_pop_a - r_s1_pop_b)
                                              : (r_s1_pop_b - r_s1_pop_a);
    assign w_e   = {(r_s1_pop_a < r_s1_pop_b), w_mag};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start_ok)   w_state_next = ST_SAMPLE;
            ST_SAMPLE: if (w_last_kept)  w_state_next = ST_FLUSH;
            ST_FLUSH:  if (w_last_write) w_state_next = ST_IDLE;
            default:                     w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kept_cnt <= '0;
            r_addr_cnt <= '0;
            r_s1_valid <= 1'b0;
            r_s1_pop_a <= '0;
            r_s1_pop_b <= '0;
            r_s1_v     <= '0;
            r_wea      <= 1'b0;
            r_wr_addr  <= '0;
            r_v        <= '0;
            r_e        <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= w_last_write;
            r_s1_valid <= w_keep;
            r_wea      <= r_s1_valid;

            if (w_start_ok) begin
                r_kept_cnt <= '0;
            end else if (w_keep && (r_kept_cnt != c_last)) begin
                r_kept_cnt <= r_kept_cnt + 1'b1;
            end

            if (w_keep) begin
                r_s1_pop_a <= w_pop_a;
                r_s1_pop_b <= w_pop_b;
                r_s1_v     <= w_tern.v;
            end

            if (w_start_ok) begin
                r_addr_cnt <= '0;
            end else if (r_s1_valid) begin
                r_wr_addr <= r_addr_cnt;
                r_v       <= r_s1_v;
                r_e       <= w_e;
                if (r_addr_cnt != c_last) begin
                    r_addr_cnt <= r_addr_cnt + 1'b1;
                end
            end
        end
    end

`ifdef ERROR_SAMPLER_STATS_EN
    logic [15:0] r_reject_count;

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_reject_count <= '0;
        end else if (w_drop && (r_reject_count != 16'hFFFF)) begin
            r_reject_count <= r_reject_count + 16'd1;
        end
    end

    assign reject_count = r_reject_count;
`else
    logic w_drop_unused;
    assign w_drop_unused = w_drop;
`endif

    assign busy               = (r_state != ST_IDLE);
    assign done               = r_done;
    assign error_bram_wea     = r_wea;
    assign error_bram_wr_addr = r_wr_addr;
    assign v_bram_wr_data     = r_v;
    assign e1_bram_wr_data    = r_e;

endmodule

`default_nettype wire
